// File: rtl/reg_pipe_chain.sv
// Enable-gated pipeline delay line: DEPTH register stages with travelling valid
// bits, a runtime output tap, synchronous flush and a fill-count "primed" flag.

module reg_pipe_chain_stage #(
   parameter int               WIDTH   = 18,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en_i,
   input  logic             clr_i,
   input  logic [WIDTH-1:0] d_i,
   input  logic             vld_i,
   output logic [WIDTH-1:0] q_o,
   output logic             vld_o
);
   logic [WIDTH-1:0] s_q, s_d;
   logic             v_q, v_d;

   // clr outranks en; flushed stages carry no valid history.
   always_comb begin
      s_d = s_q;
      v_d = v_q;
      if (clr_i) begin
         s_d = RST_VAL;
         v_d = 1'b0;
      end else if (en_i) begin
         s_d = d_i;
         v_d = vld_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_q <= RST_VAL;
         v_q <= 1'b0;
      end else begin
         s_q <= s_d;
         v_q <= v_d;
      end
   end

   assign q_o   = s_q;
   assign vld_o = v_q;
endmodule

module reg_pipe_chain #(
   parameter int               WIDTH   = 18,
   parameter int               DEPTH   = 2,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic [WIDTH-1:0] d,
   input  logic             vld_in,
   input  logic [3:0]       tap,
   output logic [WIDTH-1:0] q,
   output logic             vld_out,
   output logic             primed
);
   localparam logic [3:0] DEPTH4 = 4'(DEPTH);

   // Index 0 is the live input, so the tap mux and the chain share one array.
   logic [DEPTH:0][WIDTH-1:0] data;
   logic [DEPTH:0]            vld;
   logic [3:0]                cnt_q, cnt_d, tap_eff;

   assign data[0] = d;
   assign vld[0]  = vld_in;

   for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
      reg_pipe_chain_stage #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_stage (
         .clk   (clk),
         .rst   (rst),
         .en_i  (en),
         .clr_i (clr),
         .d_i   (data[k-1]),
         .vld_i (vld[k-1]),
         .q_o   (data[k]),
         .vld_o (vld[k])
      );
   end

   // Fill counter saturates at DEPTH; with DEPTH=0 it sits at 0 and primed is stuck high.
   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (en && (cnt_q != DEPTH4))
         cnt_d = cnt_q + 4'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign primed  = (cnt_q == DEPTH4);
   assign tap_eff = (tap > DEPTH4) ? DEPTH4 : tap;

   always_comb begin
      q       = data[0];
      vld_out = vld[0];
      for (int k = 1; k <= DEPTH; k++) begin
         if (tap_eff == 4'(k)) begin
            q       = data[k];
            vld_out = vld[k];
         end
      end
   end
endmodule

// File: tb/tb_reg_pipe_chain.sv
// Directed bench for reg_pipe_chain: three instances (DEPTH 3, 2 and 0) share stimulus.

module tb_reg_pipe_chain;
   logic        clk = 1'b0;
   logic        rst, en, clr, vld_in;
   logic [17:0] d;
   logic [3:0]  tap;
   logic [17:0] qa, qb, qc;
   logic        va, vb, vc, pa, pb, pc;
   int          pass_cnt = 0;
   int          total = 0;

   always #5 clk = ~clk;

   reg_pipe_chain #(.WIDTH(18), .DEPTH(3), .RST_VAL(18'h0)) u_a (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .d(d), .vld_in(vld_in), .tap(tap),
      .q(qa), .vld_out(va), .primed(pa));
   reg_pipe_chain #(.WIDTH(18), .DEPTH(2), .RST_VAL(18'h3FFFF)) u_b (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .d(d), .vld_in(vld_in), .tap(tap),
      .q(qb), .vld_out(vb), .primed(pb));
   reg_pipe_chain #(.WIDTH(18), .DEPTH(0), .RST_VAL(18'h0)) u_c (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .d(d), .vld_in(vld_in), .tap(tap),
      .q(qc), .vld_out(vc), .primed(pc));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b0; clr = 1'b0; d = 18'h2A; vld_in = 1'b1; tap = 4'd3;
      #12;
      total++;
      if ({qa, va, pa} !== {18'h0, 1'b0, 1'b0})
         $display("FAIL reset_a got q=%h v=%b p=%b want 0/0/0", qa, va, pa);
      else pass_cnt++;
      total++;
      if ({qb, vb, pb} !== {18'h3FFFF, 1'b0, 1'b0})
         $display("FAIL reset_b got q=%h v=%b p=%b want 3ffff/0/0", qb, vb, pb);
      else pass_cnt++;
      total++;
      if ({qc, vc, pc} !== {18'h2A, 1'b1, 1'b1})
         $display("FAIL reset_c got q=%h v=%b p=%b want 2a/1/1", qc, vc, pc);
      else pass_cnt++;
      tap = 4'd0;
      #1;
      total++;
      if ({qa, va} !== {18'h2A, 1'b1})
         $display("FAIL reset_tap0 got q=%h v=%b want 2a/1", qa, va);
      else pass_cnt++;
      tap = 4'd3;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_fill();
      logic [17:0] ea, eb;
      en = 1'b1; vld_in = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         d = 18'(i);
         tick();
         ea = (i >= 3) ? 18'(i - 2) : 18'h0;
         eb = (i >= 2) ? 18'(i - 1) : 18'h3FFFF;
         total++;
         if ({qa, va, pa} !== {ea, i >= 3, i >= 3})
            $display("FAIL fill_a edge%0d got q=%h v=%b p=%b want %h/%b/%b",
                     i, qa, va, pa, ea, i >= 3, i >= 3);
         else pass_cnt++;
         total++;
         if ({qb, vb, pb} !== {eb, i >= 2, i >= 2})
            $display("FAIL fill_b_sat edge%0d got q=%h v=%b p=%b want %h/%b/%b",
                     i, qb, vb, pb, eb, i >= 2, i >= 2);
         else pass_cnt++;
      end
   endtask

   task automatic test_hold();
      d = 18'd7;
      tick();                       // stages now 7,5,4
      en = 1'b0; d = 18'd8;
      for (int i = 0; i < 4; i++) begin
         tick();
         total++;
         if ({qa, va, pa} !== {18'd4, 1'b1, 1'b1})
            $display("FAIL hold cyc%0d got q=%h v=%b p=%b want 4/1/1", i, qa, va, pa);
         else pass_cnt++;
      end
      en = 1'b1; d = 18'd9;
      tick();
      total++;
      if (qa !== 18'd5) $display("FAIL hold_resume1 got q=%h want 5", qa);
      else pass_cnt++;
      tick();
      total++;
      if (qa !== 18'd7) $display("FAIL hold_resume2 got q=%h want 7", qa);
      else pass_cnt++;
   endtask

   task automatic test_flush();
      for (int i = 10; i <= 12; i++) begin
         d = 18'(i);
         tick();
      end
      total++;
      if (qa !== 18'd10) $display("FAIL flush_pre got q=%h want 10", qa);
      else pass_cnt++;
      clr = 1'b1; d = 18'd99;
      tick();
      clr = 1'b0; d = 18'd0; vld_in = 1'b0;
      for (int t = 1; t <= 3; t++) begin
         tap = 4'(t);
         #1;
         total++;
         if ({qa, va} !== {18'h0, 1'b0})
            $display("FAIL flush_tap%0d got q=%h v=%b want 0/0", t, qa, va);
         else pass_cnt++;
      end
      total++;
      if ({pa, pb, qb} !== {1'b0, 1'b0, 18'h3FFFF})
         $display("FAIL flush_primed got pa=%b pb=%b qb=%h want 0/0/3ffff", pa, pb, qb);
      else pass_cnt++;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++;
         if (qa !== 18'h0) $display("FAIL flush_no99 cyc%0d got q=%h want 0", i, qa);
         else pass_cnt++;
      end
      // flush while disabled
      vld_in = 1'b1; d = 18'd3;
      tick();
      en = 1'b0; clr = 1'b1;
      tick();
      clr = 1'b0;
      tap = 4'd1;
      #1;
      total++;
      if ({qa, va, pa} !== {18'h0, 1'b0, 1'b0})
         $display("FAIL flush_en0 got q=%h v=%b p=%b want 0/0/0", qa, va, pa);
      else pass_cnt++;
   endtask

   task automatic test_tap_sweep();
      logic [3:0]  taps [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd9};
      logic [17:0] exps [5] = '{18'd42, 18'd5, 18'd6, 18'd7, 18'd7};
      en = 1'b1; vld_in = 1'b1;
      d = 18'd7; tick();
      d = 18'd6; tick();
      d = 18'd5; tick();
      en = 1'b0; d = 18'd42; vld_in = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tap = taps[i];
         #1;
         total++;
         if ({qa, va} !== {exps[i], (i != 0)})
            $display("FAIL tap_sweep tap=%0d got q=%h v=%b want %h/%b",
                     taps[i], qa, va, exps[i], (i != 0));
         else pass_cnt++;
      end
   endtask

   task automatic test_async_reset();
      tap = 4'd2;
      #1;
      total++;
      if ({qb, vb} !== {18'd6, 1'b1}) $display("FAIL arst_pre got q=%h v=%b want 6/1", qb, vb);
      else pass_cnt++;
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      total++;
      if ({qb, vb, pb} !== {18'h3FFFF, 1'b0, 1'b0})
         $display("FAIL arst_mid got q=%h v=%b p=%b want 3ffff/0/0", qb, vb, pb);
      else pass_cnt++;
      total++;
      if ({qa, va} !== {18'h0, 1'b0}) $display("FAIL arst_a got q=%h v=%b want 0/0", qa, va);
      else pass_cnt++;
      @(negedge clk);
      rst = 1'b0; en = 1'b1; d = 18'h155; vld_in = 1'b1;
      tick();
      total++;
      if ({qb, vb, pb} !== {18'h3FFFF, 1'b0, 1'b0})
         $display("FAIL arst_first got q=%h v=%b p=%b want 3ffff/0/0", qb, vb, pb);
      else pass_cnt++;
      d = 18'h0AA;
      tick();
      total++;
      if ({qb, vb, pb} !== {18'h155, 1'b1, 1'b1})
         $display("FAIL arst_second got q=%h v=%b p=%b want 155/1/1", qb, vb, pb);
      else pass_cnt++;
   endtask

   task automatic test_depth0();
      logic [17:0] dv [4] = '{18'h3FFFF, 18'h00001, 18'h2AAAA, 18'h15555};
      tap = 4'd5;
      for (int i = 0; i < 4; i++) begin
         d = dv[i]; vld_in = i[0]; en = i[1]; rst = (i == 2);
         #2;
         total++;
         if ({qc, vc, pc} !== {dv[i], i[0], 1'b1})
            $display("FAIL depth0 i=%0d got q=%h v=%b p=%b want %h/%b/1",
                     i, qc, vc, pc, dv[i], i[0]);
         else pass_cnt++;
         if (i == 1) tick();
      end
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_fill();
      test_hold();
      test_flush();
      test_tap_sweep();
      test_async_reset();
      test_depth0();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
